audio_steer: RTL and testbench

Parametrised successor to the two-channel direction/step controller. It averages left/right intensity samples over a power-of-two window and compares the averaged difference against a threshold with hysteresis. Each window yields a direction, a saturated step magnitude and a move flag. The block sits between the audio-intensity front end and the steering/motor step logic, with valid/ready handshakes on both sides.

---
 rtl/audio_steer_pkg.sv | 19 +
 rtl/audio_steer_if.sv | 27 ++
 rtl/audio_window_acc.sv | 38 +++
 rtl/audio_steer.sv | 138 +++++++++++++
 tb/tb_audio_steer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/audio_steer_pkg.sv
// Shared definitions for the audio steering block and the step logic behind it.
package audio_pkg;

    // Controller phases: collecting a window, then evaluating/publishing it.
    typedef enum logic {
        ACCUM = 1'b0,
        EVAL  = 1'b1
    } state_e;

    // Direction encoding shared with the downstream step logic.
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Datapath lanes: one accumulator per audio channel.
    localparam int NUM_LANES = 2;
    localparam int LANE_L    = 0;
    localparam int LANE_R    = 1;

endpackage

// File: rtl/audio_steer_if.sv
// Sample-in / result-out handshake bundle for audio_steer.
interface audio_steer_if #(
    parameter int WIDTH     = 12,
    parameter int VAL_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     intL;
    logic [WIDTH-1:0]     intR;
    logic                 out_valid;
    logic                 out_ready;
    logic                 dir;
    logic [VAL_WIDTH-1:0] val;
    logic                 move;

    // Front end / step-logic side: drives samples, consumes results.
    modport master (
        output in_valid, intL, intR, out_ready,
        input  in_ready, out_valid, dir, val, move
    );

    // Steering block side.
    modport slave (
        input  in_valid, intL, intR, out_ready,
        output in_ready, out_valid, dir, val, move
    );
endinterface

// File: rtl/audio_window_acc.sv
// Per-channel window accumulator: running sum plus sample count, cleared as
// a unit when the window result is taken.
module audio_window_acc #(
    parameter int WIDTH    = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      add,
    input  logic                      clr,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH+AVG_LOG2-1:0] sum,
    output logic                      last
);
    localparam int SW = WIDTH + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [CW-1:0] cnt;

    // Sum is sized so a full window of max-scale samples cannot overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
            cnt <= '0;
        end else if (clr) begin
            sum <= '0;
            cnt <= '0;
        end else if (add) begin
            sum <= sum + SW'(din);
            cnt <= cnt + CW'(1);
        end
    end

    // High on the cycle the final sample of the window is being accepted.
    assign last = add && (cnt == CNT_LAST);

endmodule

// File: rtl/audio_steer.sv
// Window-averaged left/right intensity comparator with hysteresis, producing
// a direction, saturated step magnitude and move flag per window.
module audio_steer
    import audio_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int AVG_LOG2  = 2,
    parameter int THRESHOLD = 100,
    parameter int HYST      = 20,
    parameter int SHIFT     = 4,
    parameter int VAL_WIDTH = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    audio_steer_if.slave bus
);
    localparam int SW = WIDTH + AVG_LOG2;          // accumulator width
    localparam int MW = SW + 1;                    // signed difference width
    localparam int EW = (MW > VAL_WIDTH) ? MW : VAL_WIDTH;

    localparam logic [MW-1:0] THR_HI = MW'(THRESHOLD);
    localparam logic [MW-1:0] THR_LO = MW'(THRESHOLD - HYST);
    localparam logic [EW-1:0] VAL_MAX = EW'({VAL_WIDTH{1'b1}});

    state_e state;
    logic   run_q;
    logic   accept;
    logic   load;
    logic   window_done;

    logic [NUM_LANES-1:0][WIDTH-1:0] lane_din;
    logic [NUM_LANES-1:0][SW-1:0]    lane_sum;
    logic [NUM_LANES-1:0]            lane_last;

    logic                 out_valid_q;
    logic                 dir_q;
    logic                 move_q;
    logic [VAL_WIDTH-1:0] val_q;

    logic signed [MW-1:0] avg_l;
    logic signed [MW-1:0] avg_r;
    logic signed [MW-1:0] diff;
    logic [MW-1:0]        mag;
    logic [MW-1:0]        thr;
    logic [MW-1:0]        excess;
    logic [EW-1:0]        excess_w;
    logic                 cand_dir;
    logic                 hit;
    logic [VAL_WIDTH-1:0] val_n;

    assign lane_din[LANE_L] = bus.intL;
    assign lane_din[LANE_R] = bus.intR;

    // in_ready stays low while reset is held and for the first edge after it.
    assign bus.in_ready = run_q && (state == ACCUM);
    assign accept       = bus.in_valid && bus.in_ready;
    assign window_done  = &lane_last;
    assign load         = (state == EVAL) && (!out_valid_q || bus.out_ready);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        audio_window_acc #(
            .WIDTH    (WIDTH),
            .AVG_LOG2 (AVG_LOG2)
        ) u_acc (
            .clock   (clock),
            .reset_n (reset_n),
            .add     (accept),
            .clr     (load),
            .din     (lane_din[g]),
            .sum     (lane_sum[g]),
            .last    (lane_last[g])
        );
    end

    // Run flag: enables input acceptance once out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    // Two-phase controller; EVAL waits here while the previous result is unread.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ACCUM;
        end else begin
            case (state)
                ACCUM:   if (window_done) state <= EVAL;
                EVAL:    if (load)        state <= ACCUM;
                default:                  state <= ACCUM;
            endcase
        end
    end

    // Average, difference, effective threshold and saturated step magnitude.
    always_comb begin
        avg_l    = $signed({1'b0, lane_sum[LANE_L] >> AVG_LOG2});
        avg_r    = $signed({1'b0, lane_sum[LANE_R] >> AVG_LOG2});
        diff     = avg_l - avg_r;
        mag      = diff[MW-1] ? $unsigned(-diff) : $unsigned(diff);
        cand_dir = dir_q;
        if (diff != '0) cand_dir = diff[MW-1] ? DIR_RIGHT : DIR_LEFT;
        // Hysteresis only helps when continuing a move in the same direction.
        thr      = (move_q && (cand_dir == dir_q)) ? THR_LO : THR_HI;
        hit      = mag > thr;
        excess   = (mag - thr) >> SHIFT;
        excess_w = EW'(excess);
        val_n    = (excess_w > VAL_MAX) ? VAL_WIDTH'({VAL_WIDTH{1'b1}})
                                        : excess_w[VAL_WIDTH-1:0];
    end

    // Result slot: a load wins over retirement so back-to-back results never gap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            dir_q       <= DIR_RIGHT;
            move_q      <= 1'b0;
            val_q       <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            if (hit) begin
                move_q <= 1'b1;
                dir_q  <= cand_dir;
                val_q  <= val_n;
            end else begin
                move_q <= 1'b0;
                val_q  <= '0;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dir       = dir_q;
    assign bus.move      = move_q;
    assign bus.val       = val_q;

endmodule

// File: tb/tb_audio_steer.sv
// Directed bench for audio_steer: expected results are queued as each window
// is driven and popped as the block publishes them.
module tb_audio_steer;
    logic clock;
    logic reset_n;

    audio_steer_if #(.WIDTH(12), .VAL_WIDTH(8)) bus ();
    audio_steer_if #(.WIDTH(12), .VAL_WIDTH(8)) bus2 ();

    audio_steer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    audio_steer #(.SHIFT(2)) dut_sat (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic dir;
        int   val;
        logic move;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic d, input int v, input logic m);
        exp_t e;
        e.dir = d; e.val = v; e.move = m;
        sb.push_back(e);
    endtask

    // Present one pair and hold it until accepted (bounded).
    task automatic send(input int l, input int r);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.intL = 12'(l);
        bus.intR = 12'(r);
        while (!bus.in_ready && t < 50) begin
            @(posedge clock); #1;
            t++;
        end
        if (t >= 50) check("in_ready_timeout", bus.in_ready, 1);
        @(posedge clock); #1;
    endtask

    task automatic send_window(input int l, input int r);
        for (int i = 0; i < 4; i++) send(l, r);
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, compare against the scoreboard head.
    task automatic get_result(input string tag, input bit consume);
        exp_t e;
        int   t;
        t = 0;
        while (!bus.out_valid && t < 30) begin
            @(posedge clock); #1;
            t++;
        end
        check({tag, "_valid"}, bus.out_valid, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_dir"},  bus.dir,  e.dir);
            check({tag, "_val"},  bus.val,  e.val);
            check({tag, "_move"}, bus.move, e.move);
        end
        if (consume) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        int hits;
        int acc;
        int t;
        bus.in_valid = 1'b0; bus.intL = '0; bus.intR = '0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.intL = '0; bus2.intR = '0; bus2.out_ready = 1'b1;
        reset_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready",  bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dir",       bus.dir, 0);
        check("rst_val",       bus.val, 0);
        check("rst_move",      bus.move, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic step with latency check
        push_exp(1'b0, 25, 1'b1);
        send_window(1000, 1500);
        check("lat_eval_in_ready", bus.in_ready, 0);
        check("lat_eval_out_valid", bus.out_valid, 0);
        @(posedge clock); #1;
        check("lat_t1_out_valid", bus.out_valid, 1);
        get_result("basic", 1'b1);
        check("basic_retired", bus.out_valid, 0);

        // Left louder, then dead-band keeps dir=1
        push_exp(1'b1, 25, 1'b1);
        send_window(1500, 1000);
        get_result("left", 1'b1);
        push_exp(1'b1, 0, 1'b0);
        send_window(2000, 2000);
        get_result("deadband", 1'b1);

        // Hysteresis
        push_exp(1'b0, 6, 1'b1);
        send_window(1000, 1200);
        get_result("hyst200", 1'b1);
        push_exp(1'b0, 0, 1'b1);
        send_window(1000, 1090);
        get_result("hyst90", 1'b1);
        push_exp(1'b0, 0, 1'b0);
        send_window(1000, 1070);
        get_result("hyst70", 1'b1);
        push_exp(1'b0, 6, 1'b1);
        send_window(1000, 1200);
        get_result("rev_pre", 1'b1);
        push_exp(1'b0, 0, 1'b0);
        send_window(1090, 1000);
        get_result("rev90", 1'b1);

        // Backpressure across two windows
        bus.out_ready = 1'b0;
        push_exp(1'b0, 25, 1'b1);
        send_window(100, 600);
        push_exp(1'b0, 181, 1'b1);
        send(10, 3000);
        send(20, 3001);
        send(30, 3002);
        send(40, 3003);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("bp_in_ready",  bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_val_hold",  bus.val, 25);
        end
        get_result("bp_first", 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        get_result("bp_second", 1'b1);
        check("bp_drained", bus.out_valid, 0);

        // Reset mid-window
        send(4000, 0);
        send(4000, 0);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_val",       bus.val, 0);
        check("mid_rst_move",      bus.move, 0);
        check("mid_rst_dir",       bus.dir, 0);
        check("mid_rst_in_ready",  bus.in_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        push_exp(1'b0, 18, 1'b1);
        send_window(0, 400);
        get_result("post_rst", 1'b1);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) hits++;
            @(posedge clock); #1;
        end
        check("post_rst_single", hits, 0);
        check("sb_drained", sb.size(), 0);

        // Saturation on the SHIFT=2 instance
        bus2.in_valid = 1'b1;
        bus2.intL = 12'd0;
        bus2.intR = 12'd4095;
        acc = 0;
        t = 0;
        while (acc < 4 && t < 40) begin
            if (bus2.in_ready) acc++;
            @(posedge clock); #1;
            t++;
        end
        bus2.in_valid = 1'b0;
        check("sat_accepted", acc, 4);
        t = 0;
        while (!bus2.out_valid && t < 20) begin
            @(posedge clock); #1;
            t++;
        end
        check("sat_valid", bus2.out_valid, 1);
        check("sat_val",   bus2.val, 255);
        check("sat_dir",   bus2.dir, 0);
        check("sat_move",  bus2.move, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
